// File: rtl/ifetch_buf_if.sv
// Fetch-unit bus bundle: icache request/response channel and the DEC delivery channel.
// master = the fetch unit, slave = icache + DEC side.
interface ifetch_buf_if #(
    parameter int XLEN = 32
);
    logic            icache_req_v_o;
    logic            icache_ready_i;
    logic [XLEN-1:0] icache_adr_o;
    logic            icache_rsp_v_i;
    logic [31:0]     icache_instr_i;
    logic            dec_v_o;
    logic            dec_ready_i;
    logic [31:0]     instr_q_o;
    logic [XLEN-1:0] pc_q_o;

    modport master (
        output icache_req_v_o, icache_adr_o, dec_v_o, instr_q_o, pc_q_o,
        input  icache_ready_i, icache_rsp_v_i, icache_instr_i, dec_ready_i
    );

    modport slave (
        input  icache_req_v_o, icache_adr_o, dec_v_o, instr_q_o, pc_q_o,
        output icache_ready_i, icache_rsp_v_i, icache_instr_i, dec_ready_i
    );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction fetch unit with a DEPTH-entry prefetch buffer between a variable-latency,
// in-order icache and DEC; an EXE flush drops buffered and in-flight fetches.

module ifetch_buf_chk (
    input logic clk,
    input logic reset_n,
    input logic rsp_v,
    input logic drop_zero,
    input logic ptr_eq,
    input logic dec_v,
    input logic head_filled
);
    // A kept response needs an outstanding request to land in.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp_v && drop_zero && ptr_eq));

    // Anything offered to DEC must already hold its instruction.
    a_head_filled: assert property (@(posedge clk) disable iff (!reset_n)
        dec_v |-> head_filled);
endmodule

module ifetch_buf #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int PC_INC = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] reset_adr_i,
    input  logic            flush_v_q_i,
    input  logic [XLEN-1:0] pc_data_q_i,
    ifetch_buf_if.master    bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t            alloc_r, fill_r, rd_r, drop_cnt_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic            reset_n_q_r;
    logic [XLEN-1:0] pc_mem_r    [DEPTH];
    logic [31:0]     instr_mem_r [DEPTH];
    logic [DEPTH-1:0] filled_r;

    logic            boot_s, full_s, drop_zero_s, req_v_s, accept_s;
    logic            ptr_eq_s, keep_s, drop_rsp_s, dec_v_s, pop_s;
    logic [XLEN-1:0] adr_s;
    ptr_t            occ_s, pending_s, drop_flush_s;

    assign boot_s      = reset_n & ~reset_n_q_r;
    assign adr_s       = boot_s ? reset_adr_i : fetch_pc_r;
    // Occupancy never exceeds DEPTH, so the MSB alone marks "full".
    assign occ_s       = alloc_r - rd_r;
    assign full_s      = occ_s[PTR_W-1];
    assign drop_zero_s = (drop_cnt_r == '0);
    assign req_v_s     = reset_n & ~flush_v_q_i & ~full_s & drop_zero_s;
    assign accept_s    = req_v_s & bus.icache_ready_i;
    assign ptr_eq_s    = (fill_r == alloc_r);
    assign keep_s      = bus.icache_rsp_v_i & drop_zero_s & ~ptr_eq_s;
    assign drop_rsp_s  = bus.icache_rsp_v_i & ~drop_zero_s;
    assign dec_v_s     = (rd_r != fill_r);
    assign pop_s       = dec_v_s & bus.dec_ready_i & ~flush_v_q_i;
    assign pending_s   = alloc_r - fill_r;
    // Responses still owed after a flush; one consumed this cycle is already accounted for.
    assign drop_flush_s = drop_cnt_r + pending_s - ptr_t'(keep_s | drop_rsp_s);

    assign bus.icache_req_v_o = req_v_s;
    assign bus.icache_adr_o   = adr_s;
    assign bus.dec_v_o        = dec_v_s;
    assign bus.instr_q_o      = instr_mem_r[rd_r[IDX_W-1:0]];
    assign bus.pc_q_o         = pc_mem_r[rd_r[IDX_W-1:0]];

    // Pointers, fetch PC, drop counter and boot tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_r     <= '0;
            fill_r      <= '0;
            rd_r        <= '0;
            drop_cnt_r  <= '0;
            fetch_pc_r  <= '0;
            reset_n_q_r <= 1'b0;
        end else begin
            reset_n_q_r <= 1'b1;
            if (flush_v_q_i) begin
                alloc_r    <= '0;
                fill_r     <= '0;
                rd_r       <= '0;
                fetch_pc_r <= pc_data_q_i;
                drop_cnt_r <= drop_flush_s;
            end else begin
                if (accept_s) begin
                    alloc_r    <= alloc_r + ptr_t'(1);
                    fetch_pc_r <= adr_s + XLEN'(PC_INC);
                end else if (boot_s) begin
                    fetch_pc_r <= reset_adr_i;
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                end
                if (drop_rsp_s) begin
                    drop_cnt_r <= drop_cnt_r - ptr_t'(1);
                end
                if (keep_s) begin
                    fill_r <= fill_r + ptr_t'(1);
                end
                if (pop_s) begin
                    rd_r <= rd_r + ptr_t'(1);
                end
            end
        end
    end

    // Buffer storage: PC on request accept, instruction on kept response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= '0;
                instr_mem_r[i] <= '0;
            end
            filled_r <= '0;
        end else begin
            if (accept_s) begin
                pc_mem_r[alloc_r[IDX_W-1:0]] <= adr_s;
                filled_r[alloc_r[IDX_W-1:0]] <= 1'b0;
            end
            if (keep_s && !flush_v_q_i) begin
                instr_mem_r[fill_r[IDX_W-1:0]] <= bus.icache_instr_i;
                filled_r[fill_r[IDX_W-1:0]]    <= 1'b1;
            end
        end
    end

    ifetch_buf_chk u_chk (
        .clk         (clk),
        .reset_n     (reset_n),
        .rsp_v       (bus.icache_rsp_v_i),
        .drop_zero   (drop_zero_s),
        .ptr_eq      (ptr_eq_s),
        .dec_v       (dec_v_s),
        .head_filled (filled_r[rd_r[IDX_W-1:0]])
    );
endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf: behavioural icache with configurable latency and a
// scoreboard of expected DEC {pc, instr} pairs pushed on each accepted fetch.
module tb_ifetch_buf;
    typedef struct { logic [31:0] adr; int due; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } de_t;

    logic        clk, reset_n, flush;
    logic [31:0] reset_adr, pc_data;
    int          checks, failures, cyc, lat, acc_cnt, pop_cnt;
    int          first_dec_cyc, mark, fa_cyc, rel_cyc, n0;
    logic [31:0] exp_next_adr, a0;
    logic        s_req, s_dec_v, s_acc;
    logic [31:0] s_adr;
    fl_t         infl_q[$];
    de_t         exp_dec_q[$];

    ifetch_buf_if #(.XLEN(32)) bus ();

    ifetch_buf #(.XLEN(32), .DEPTH(4), .PC_INC(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reset_adr_i (reset_adr),
        .flush_v_q_i (flush),
        .pc_data_q_i (pc_data),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive icache response, sample DUT mid-cycle, update model, advance.
    task automatic cycle();
        de_t e;
        fl_t f;
        if (infl_q.size() > 0 && infl_q[0].due <= cyc) begin
            bus.icache_rsp_v_i = 1'b1;
            bus.icache_instr_i = instr_of(infl_q[0].adr);
            void'(infl_q.pop_front());
        end else begin
            bus.icache_rsp_v_i = 1'b0;
            bus.icache_instr_i = $urandom;
        end
        #1;
        s_req   = bus.icache_req_v_o;
        s_adr   = bus.icache_adr_o;
        s_dec_v = bus.dec_v_o;
        s_acc   = s_req & bus.icache_ready_i;
        if (flush) begin
            chk("flush_no_req", {31'd0, s_req}, 32'd0);
            exp_dec_q.delete();
            exp_next_adr = pc_data;
        end else begin
            if (s_acc) begin
                chk("req_adr", s_adr, exp_next_adr);
                f.adr = s_adr;
                f.due = cyc + lat;
                infl_q.push_back(f);
                e.pc    = exp_next_adr;
                e.instr = instr_of(exp_next_adr);
                exp_dec_q.push_back(e);
                exp_next_adr = exp_next_adr + 32'd4;
                acc_cnt++;
                if (fa_cyc < 0 && cyc >= mark) fa_cyc = cyc;
            end
            if (s_dec_v && bus.dec_ready_i) begin
                if (exp_dec_q.size() == 0) begin
                    chk("dec_unexpected", {31'd0, s_dec_v}, 32'd0);
                end else begin
                    e = exp_dec_q.pop_front();
                    chk("dec_pc", bus.pc_q_o, e.pc);
                    chk("dec_instr", bus.instr_q_o, e.instr);
                end
                pop_cnt++;
                if (first_dec_cyc < 0) first_dec_cyc = cyc;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] adr);
        reset_n = 1'b0;
        flush   = 1'b0;
        infl_q.delete();
        exp_dec_q.delete();
        bus.icache_rsp_v_i = 1'b0;
        reset_adr = adr;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_v", {31'd0, bus.icache_req_v_o}, 32'd0);
        chk("rst_adr", bus.icache_adr_o, 32'd0);
        chk("rst_dec_v", {31'd0, bus.dec_v_o}, 32'd0);
        chk("rst_instr", bus.instr_q_o, 32'd0);
        chk("rst_pc", bus.pc_q_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_next_adr = adr;
        cyc = 0; acc_cnt = 0; pop_cnt = 0;
        first_dec_cyc = -1; fa_cyc = -1; mark = 0;
    endtask

    initial begin
        checks = 0; failures = 0; lat = 1;
        reset_n = 1'b0; flush = 1'b0; pc_data = 32'd0; reset_adr = 32'd0;
        bus.icache_ready_i = 1'b1;
        bus.dec_ready_i    = 1'b1;
        bus.icache_rsp_v_i = 1'b0;
        bus.icache_instr_i = 32'd0;
        @(negedge clk);

        // Boot, everything ready, 1-cycle icache
        do_reset(32'h8000_0000);
        lat = 1;
        repeat (10) cycle();
        chk("boot_first_dec_cyc", first_dec_cyc, 32'd2);
        chk("boot_acc_cnt", acc_cnt, 32'd10);

        // DEC back-pressure fills the buffer
        do_reset(32'h0000_0100);
        bus.dec_ready_i = 1'b0;
        repeat (8) cycle();
        chk("bp_acc_cnt", acc_cnt, 32'd4);
        chk("bp_req_v_full", {31'd0, s_req}, 32'd0);
        chk("bp_dec_v", {31'd0, s_dec_v}, 32'd1);
        bus.dec_ready_i = 1'b1;
        #1;
        chk("bp_no_bypass", {31'd0, bus.icache_req_v_o}, 32'd0);
        rel_cyc = cyc; mark = cyc; fa_cyc = -1;
        repeat (8) cycle();
        chk("bp_resume_cyc", fa_cyc, rel_cyc + 1);
        chk("bp_pops", {31'd0, pop_cnt >= 4}, 32'd1);

        // icache stall holds the address
        bus.icache_ready_i = 1'b0;
        cycle();
        a0 = s_adr; n0 = acc_cnt;
        cycle();
        chk("stall_adr1", s_adr, a0);
        cycle();
        chk("stall_adr2", s_adr, a0);
        chk("stall_req_v", {31'd0, s_req}, 32'd1);
        chk("stall_no_alloc", acc_cnt, n0);
        bus.icache_ready_i = 1'b1;
        cycle();
        chk("stall_one_accept", acc_cnt, n0 + 1);
        cycle();
        chk("stall_next_adr", s_adr, a0 + 32'd4);

        // Flush with two requests in flight, 3-cycle icache
        do_reset(32'h0000_0200);
        lat = 3;
        cycle(); cycle();
        flush = 1'b1; pc_data = 32'h0000_1000;
        mark = cyc; fa_cyc = -1;
        cycle();
        flush = 1'b0;
        repeat (10) cycle();
        chk("fl_resume_cyc", fa_cyc, 32'd5);
        chk("fl_first_dec_cyc", first_dec_cyc, 32'd9);

        // Flush coinciding with a response and a pop, 2-cycle icache
        do_reset(32'h0000_0300);
        lat = 2;
        repeat (4) cycle();
        flush = 1'b1; pc_data = 32'h0000_2000;
        mark = cyc; fa_cyc = -1;
        cycle();
        chk("fc_dec_v_in_flush", {31'd0, s_dec_v}, 32'd1);
        flush = 1'b0;
        cycle();
        chk("fc_empty_after", {31'd0, s_dec_v}, 32'd0);
        chk("fc_req_blocked", {31'd0, s_req}, 32'd0);
        repeat (8) cycle();
        chk("fc_resume_cyc", fa_cyc, 32'd6);

        // Address wrap-around
        do_reset(32'hFFFF_FFF8);
        lat = 1;
        repeat (6) cycle();
        chk("wrap_acc_cnt", acc_cnt, 32'd6);

        // Flush in the boot cycle
        do_reset(32'h0000_5000);
        flush = 1'b1; pc_data = 32'h0000_0400;
        #1;
        chk("bf_boot_adr", bus.icache_adr_o, 32'h0000_5000);
        mark = 0; fa_cyc = -1;
        cycle();
        flush = 1'b0;
        repeat (4) cycle();
        chk("bf_resume_cyc", fa_cyc, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
